// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the program counter, drives the instruction
// memory and the external PC+4 adder, and produces the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_s,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid
);

  logic [31:0] pc;

  // Memory and adder operands come straight from pc, no gating.
  assign imem_addr = pc;
  assign add_a     = pc;
  assign add_b     = 32'd4;

  // Next-PC select: reset, then redirect (beats stall), then hold, then sequential.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (br_taken) begin
      pc <= {br_target[31:2], 2'b00};
    end else if (!stall) begin
      pc <= add_s;
    end
  end

  // IF/ID register: a redirect or flush squashes the fetch even when stalled.
  always_ff @(posedge clk) begin
    if (rst || br_taken || flush) begin
      ifid_pc    <= 32'd0;
      ifid_pc4   <= 32'd0;
      ifid_instr <= NOP;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_pc    <= pc;
      ifid_pc4   <= add_s;
      ifid_instr <= imem_data;
      ifid_valid <= 1'b1;
    end
  end

endmodule
